// File: rtl/mux_rr_stream.sv
// N-channel valid/ready stream multiplexer with fixed or round-robin channel
// selection feeding a single registered output slot.
module mux_rr_stream #(
    parameter int unsigned  N_CH = 4,
    parameter int unsigned  DW   = 8,
    localparam int unsigned SELW = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N_CH-1:0]    in_valid,
    input  logic [N_CH*DW-1:0] in_data,
    output logic [N_CH-1:0]    in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [SELW-1:0]    out_ch
);

    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
    logic [SELW-1:0] ptr_q, ptr_d;

    logic            grant_valid;
    logic [SELW-1:0] grant_idx;
    logic [DW-1:0]   grant_data;
    logic            slot_free;
    logic            xfer;

    assign slot_free = !out_valid_q || out_ready;

    // Grant selection: fixed index in mode 0, rotating search from ptr+1 in mode 1.
    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (!mode) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (SELW'(i) == sel && in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SELW'(i);
                end
            end
        end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                idx = (32'(ptr_q) + 32'd1 + k) % N_CH;
                for (int unsigned j = 0; j < N_CH; j++) begin
                    if (!grant_valid && j == idx && in_valid[j]) begin
                        grant_valid = 1'b1;
                        grant_idx   = SELW'(j);
                    end
                end
            end
        end
    end

    // Data of the granted channel; in_data never reaches an output combinationally.
    always_comb begin
        grant_data = '0;
        for (int unsigned j = 0; j < N_CH; j++) begin
            if (SELW'(j) == grant_idx) begin
                grant_data = in_data[j*DW +: DW];
            end
        end
    end

    assign xfer = rst_n && grant_valid && slot_free;

    always_comb begin
        in_ready = '0;
        for (int unsigned j = 0; j < N_CH; j++) begin
            in_ready[j] = xfer && (SELW'(j) == grant_idx);
        end
    end

    // Output slot and round-robin pointer next state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_ch_d    = grant_idx;
            if (mode) begin
                ptr_d = grant_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Pointer resets to the last channel so channel 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= SELW'(N_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
